// File: rtl/alu_pkg.sv
// Shared definitions for the multiply/divide unit: ALU control codes,
// FSM state type and a small magnitude helper.
package alu_pkg;

    localparam int MDU_XLEN = 32;

    localparam logic [3:0] ALU_MULT = 4'b0011;
    localparam logic [3:0] ALU_DIV  = 4'b0101;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FIX
    } mdu_state_t;

    // Absolute value of a two's complement word; 32'h80000000 maps to
    // itself, which is the correct unsigned magnitude.
    function automatic logic [MDU_XLEN-1:0] abs_val(input logic [MDU_XLEN-1:0] v);
        return v[MDU_XLEN-1] ? -v : v;
    endfunction

endpackage

// File: rtl/mdu_core.sv
// Iterative unsigned datapath shared by multiply (shift-add) and divide
// (restoring shift-subtract). One iteration per step cycle.
module mdu_core
    import alu_pkg::*;
#(
    parameter int XLEN = MDU_XLEN
) (
    input  logic            clk,
    input  logic            load,
    input  logic            step,
    input  logic            div_mode,
    input  logic [XLEN-1:0] mag_a,
    input  logic [XLEN-1:0] mag_b,
    output logic [XLEN-1:0] acc_hi,
    output logic [XLEN-1:0] acc_lo
);

    // Multiplicand (multiply) or divisor (divide).
    logic [XLEN-1:0] opnd;

    logic [XLEN:0]   add_x;
    logic [XLEN:0]   add_y;
    logic            add_cin;
    logic [XLEN+1:0] sum;

    // Single shared adder: adds the multiplicand for multiply, subtracts
    // the divisor (invert plus carry-in) from the shifted remainder for divide.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        add_x   = {1'b0, acc_hi};
        add_y   = acc_lo[0] ? {1'b0, opnd} : '0;
        add_cin = 1'b0;
        if (div_mode) begin
            add_x   = {acc_hi, acc_lo[XLEN-1]};
            add_y   = ~{1'b0, opnd};
            add_cin = 1'b1;
        end
        sum = {1'b0, add_x} + {1'b0, add_y} + {{(XLEN+1){1'b0}}, add_cin};
    end

    // Load operands on accept, then iterate once per step cycle.
    // NOTE: datapath registers carry no reset; they are always loaded before use and never observed otherwise.
    always_ff @(posedge clk) begin
        if (load) begin
            acc_hi <= '0;
            acc_lo <= div_mode ? mag_a : mag_b;
            opnd   <= div_mode ? mag_b : mag_a;
        end else if (step) begin
            if (div_mode) begin
                // Carry out of the subtraction means shifted remainder >= divisor.
                if (sum[XLEN+1]) begin
                    acc_hi <= sum[XLEN-1:0];
                    acc_lo <= {acc_lo[XLEN-2:0], 1'b1};
                end else begin
                    acc_hi <= add_x[XLEN-1:0];
                    acc_lo <= {acc_lo[XLEN-2:0], 1'b0};
                end
            end else begin
                acc_hi <= sum[XLEN:1];
                acc_lo <= {sum[0], acc_lo[XLEN-1:1]};
            end
        end
    end

endmodule

// File: rtl/mul_div_unit.sv
// Signed 32-bit multiply/divide unit with HI/LO result registers.
// FSM IDLE -> RUN (32 iterations) -> FIX (sign correction, write-back).
module mul_div_unit
    import alu_pkg::*;
#(
    parameter int XLEN = MDU_XLEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [3:0]      alu_con,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            hi_we,
    input  logic            lo_we,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);

    mdu_state_t      state;
    logic [5:0]      count;
    logic            div_q;
    logic            sign_a_q;
    logic            sign_b_q;
    logic            b_zero_q;
    logic [XLEN-1:0] a_q;

    logic            accept;
    logic            div_mode;
    logic [XLEN-1:0] acc_hi;
    logic [XLEN-1:0] acc_lo;
    logic [XLEN-1:0] res_hi;
    logic [XLEN-1:0] res_lo;
    logic [2*XLEN-1:0] prod_mag;
    logic [2*XLEN-1:0] prod;

    assign accept   = (state == ST_IDLE) && start &&
                      ((alu_con == ALU_MULT) || (alu_con == ALU_DIV));
    assign div_mode = accept ? (alu_con == ALU_DIV) : div_q;
    assign busy     = (state != ST_IDLE);

    mdu_core #(.XLEN(XLEN)) u_core (
        .clk      (clk),
        .load     (accept),
        .step     (state == ST_RUN),
        .div_mode (div_mode),
        .mag_a    (abs_val(a)),
        .mag_b    (abs_val(b)),
        .acc_hi   (acc_hi),
        .acc_lo   (acc_lo)
    );

    // Sign correction of the unsigned core result; divide-by-zero returns
    // the dividend as remainder and all-ones as quotient.
    always_comb begin
        prod_mag = {acc_hi, acc_lo};
        prod     = (sign_a_q ^ sign_b_q) ? -prod_mag : prod_mag;
        res_hi   = prod[2*XLEN-1:XLEN];
        res_lo   = prod[XLEN-1:0];
        if (div_q) begin
            if (b_zero_q) begin
                res_hi = a_q;
                res_lo = '1;
            end else begin
                res_hi = sign_a_q ? -acc_hi : acc_hi;
                res_lo = (sign_a_q ^ sign_b_q) ? -acc_lo : acc_lo;
            end
        end
    end

    // Control FSM, operand-sign capture and HI/LO register updates.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            count    <= '0;
            done     <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            div_q    <= 1'b0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            b_zero_q <= 1'b0;
            a_q      <= '0;
        end else begin
            // NOTE: non-blocking default then override; the last assignment in the block wins at the edge.
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (hi_we) hi <= a;
                    if (lo_we) lo <= a;
                    if (accept) begin
                        state    <= ST_RUN;
                        count    <= '0;
                        div_q    <= (alu_con == ALU_DIV);
                        sign_a_q <= a[XLEN-1];
                        sign_b_q <= b[XLEN-1];
                        b_zero_q <= (b == '0);
                        a_q      <= a;
                    end
                end
                ST_RUN: begin
                    count <= count + 6'd1;
                    if (count == 6'd31) state <= ST_FIX;
                end
                ST_FIX: begin
                    hi    <= res_hi;
                    lo    <= res_lo;
                    done  <= 1'b1;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed corner cases plus random
// multiply/divide operations checked against a plain-arithmetic model.
module tb_mul_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [3:0]  alu_con;
    logic [31:0] a;
    logic [31:0] b;
    logic        hi_we;
    logic        lo_we;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_hi;
    logic [31:0] exp_lo;

    localparam logic [3:0] OP_MULT = 4'b0011;
    localparam logic [3:0] OP_DIV  = 4'b0101;

    mul_div_unit #(.XLEN(32)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .alu_con (alu_con),
        .a       (a),
        .b       (b),
        .hi_we   (hi_we),
        .lo_we   (lo_we),
        .busy    (busy),
        .done    (done),
        .hi      (hi),
        .lo      (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: signed 64-bit arithmetic; division truncates toward zero
    // and the remainder follows the dividend sign.
    task automatic model(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                         output logic [31:0] rh, output logic [31:0] rl);
        longint sx, sy, p, q, r;
        sx = longint'(signed'(x));
        sy = longint'(signed'(y));
        if (op == OP_MULT) begin
            p  = sx * sy;
            rh = p[63:32];
            rl = p[31:0];
        end else if (y == 32'd0) begin
            rh = x;
            rl = 32'hFFFF_FFFF;
        end else begin
            q  = sx / sy;
            r  = sx % sy;
            rh = r[31:0];
            rl = q[31:0];
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Issue one operation and follow it to completion. with_hi_we asserts
    // mthi in the accepting cycle; intrude_at (1..32) drives a new start
    // plus hi_we/lo_we while busy.
    task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] opa,
                          input logic [31:0] opb, input bit with_hi_we, input int intrude_at);
        logic [31:0] rh, rl;
        model(op, opa, opb, rh, rl);
        start = 1'b1; alu_con = op; a = opa; b = opb; hi_we = with_hi_we;
        tick();
        start = 1'b0; alu_con = 4'd0; hi_we = 1'b0;
        if (with_hi_we) exp_hi = opa;
        check({tag, " busy@k"}, {31'd0, busy}, 32'd1);
        check({tag, " done@k"}, {31'd0, done}, 32'd0);
        check({tag, " hi@k"}, hi, exp_hi);
        for (int i = 1; i <= 32; i++) begin
            if (i == intrude_at) begin
                start = 1'b1; alu_con = OP_MULT; a = $urandom; b = $urandom;
                hi_we = 1'b1; lo_we = 1'b1;
            end
            tick();
            start = 1'b0; alu_con = 4'd0; hi_we = 1'b0; lo_we = 1'b0;
            check({tag, " busy run"}, {31'd0, busy}, 32'd1);
            check({tag, " done run"}, {31'd0, done}, 32'd0);
            check({tag, " hi hold"}, hi, exp_hi);
            check({tag, " lo hold"}, lo, exp_lo);
        end
        tick();
        exp_hi = rh;
        exp_lo = rl;
        check({tag, " done@k+33"}, {31'd0, done}, 32'd1);
        check({tag, " busy@k+33"}, {31'd0, busy}, 32'd0);
        check({tag, " hi"}, hi, exp_hi);
        check({tag, " lo"}, lo, exp_lo);
    endtask

    initial begin
        logic [3:0]  nop_codes [4];
        logic [31:0] ra, rb;
        nop_codes[0] = 4'b0000; nop_codes[1] = 4'b0001;
        nop_codes[2] = 4'b0100; nop_codes[3] = 4'b1111;

        // Reset, with start and hi_we asserted to show reset priority.
        rst = 1'b1; start = 1'b1; alu_con = OP_MULT; a = 32'h1234_5678; b = 32'd3;
        hi_we = 1'b1; lo_we = 1'b1;
        tick();
        tick();
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);
        check("reset hi", hi, 32'd0);
        check("reset lo", lo, 32'd0);
        rst = 1'b0; start = 1'b0; hi_we = 1'b0; lo_we = 1'b0; alu_con = 4'd0;
        exp_hi = 32'd0;
        exp_lo = 32'd0;
        tick();
        check("idle after reset busy", {31'd0, busy}, 32'd0);

        // mthi / mtlo in IDLE.
        a = 32'hCAFE_0001; hi_we = 1'b1;
        tick();
        hi_we = 1'b0; exp_hi = 32'hCAFE_0001;
        check("mthi hi", hi, exp_hi);
        check("mthi lo", lo, exp_lo);
        a = 32'hBEEF_0002; lo_we = 1'b1;
        tick();
        lo_we = 1'b0; exp_lo = 32'hBEEF_0002;
        check("mtlo lo", lo, exp_lo);
        check("mtlo hi", hi, exp_hi);

        // Unsupported codes are ignored.
        foreach (nop_codes[i]) begin
            start = 1'b1; alu_con = nop_codes[i]; a = $urandom; b = $urandom;
            tick();
            start = 1'b0;
            check("nop busy", {31'd0, busy}, 32'd0);
            check("nop done", {31'd0, done}, 32'd0);
            check("nop hi", hi, exp_hi);
            check("nop lo", lo, exp_lo);
        end

        // Directed results; consecutive calls start in the done cycle.
        run_op("mult 7*-3", OP_MULT, 32'd7, 32'hFFFF_FFFD, 1'b0, -1);
        run_op("mult max*max", OP_MULT, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0, -1);
        run_op("div -7/2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, -1);
        run_op("div 100/0", OP_DIV, 32'd100, 32'd0, 1'b0, -1);
        run_op("div min/-1", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, -1);
        run_op("div -5/0", OP_DIV, 32'hFFFF_FFFB, 32'd0, 1'b0, -1);
        run_op("mult min*min", OP_MULT, 32'h8000_0000, 32'h8000_0000, 1'b0, -1);
        run_op("mult 5*6 intrude", OP_MULT, 32'd5, 32'd6, 1'b0, 3);
        run_op("div start+mthi", OP_DIV, 32'd1000, 32'hFFFF_FFF9, 1'b1, -1);

        // Reset during RUN aborts with no done and cleared HI/LO.
        start = 1'b1; alu_con = OP_DIV; a = 32'd12345; b = 32'd7;
        tick();
        start = 1'b0; alu_con = 4'd0;
        for (int i = 1; i <= 9; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_hi = 32'd0;
        exp_lo = 32'd0;
        check("abort busy", {31'd0, busy}, 32'd0);
        check("abort done", {31'd0, done}, 32'd0);
        check("abort hi", hi, exp_hi);
        check("abort lo", lo, exp_lo);
        for (int i = 0; i < 30; i++) begin
            tick();
            check("abort no done", {31'd0, done}, 32'd0);
        end
        check("abort hi held", hi, exp_hi);
        run_op("post-abort div", OP_DIV, 32'd12345, 32'd7, 1'b0, -1);

        // Random operations with sign mixes and occasional zero divisor.
        for (int n = 0; n < 24; n++) begin
            ra = $urandom;
            rb = $urandom;
            if (n % 3 == 1) rb = rb >> $urandom_range(31, 0);
            if (n % 8 == 5) rb = 32'd0;
            run_op(n % 2 ? "rand div" : "rand mult", n % 2 ? OP_DIV : OP_MULT, ra, rb, 1'b0, -1);
        end

        tick();
        check("final done low", {31'd0, done}, 32'd0);
        check("final busy low", {31'd0, busy}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
